// File: rtl/axi_ram_responder.sv
// AXI4 slave RAM model: a byte-strobed 64-bit array served one burst at a time.
// Writes and reads share one FSM with fair tie-breaking; SLVERR marks bad beats and bursts.
module axi_ram_responder #(
  parameter int unsigned ID_WIDTH  = 6,
  parameter int unsigned MEM_SIZE  = 32'h10000,
  parameter string       INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] i_awid,
  input  logic [31:0]         i_awaddr,
  input  logic [7:0]          i_awlen,
  input  logic [2:0]          i_awsize,
  input  logic [1:0]          i_awburst,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [63:0]         i_wdata,
  input  logic [7:0]          i_wstrb,
  input  logic                i_wlast,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [ID_WIDTH-1:0] o_bid,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready,
  input  logic [ID_WIDTH-1:0] i_arid,
  input  logic [31:0]         i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic [1:0]          i_arburst,
  input  logic                i_arvalid,
  output logic                o_arready,
  output logic [ID_WIDTH-1:0] o_rid,
  output logic [63:0]         o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rlast,
  output logic                o_rvalid,
  input  logic                i_rready
);

  localparam int unsigned WORDS = MEM_SIZE / 8;
  localparam int unsigned AW    = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

  logic [63:0] mem [WORDS];

  state_e              state_q, state_d;
  logic                last_wr_q, last_wr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [8:0]          beat_q, beat_d;
  logic                err_q, err_d;
  logic                rvalid_q, rvalid_d;
  logic [63:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;

  logic                grant_w, grant_r, load_rd, mem_we, wr_oob, wr_end;
  logic [31:0]         rd_addr;
  logic [2:0]          rd_size;
  logic [1:0]          rd_burst;
  logic [8:0]          rd_beat;
  logic [7:0]          rd_len;
  logic [ID_WIDTH-1:0] rd_id;
  logic                rd_bad, rd_oob;

  function automatic logic [2:0] clip_size(input logic [2:0] sz);
    return (sz > 3'd3) ? 3'd3 : sz;
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] b);
    return (b == 2'b00) ? a : a + (32'd1 << sz);
  endfunction

  initial begin
    for (int unsigned i = 0; i < WORDS; i++) mem[i] = '0;
  end

  // Beat 0 of a read is fetched straight from the AR channel so data appears the cycle after AR.
  always_comb begin
    if (state_q == IDLE) begin
      rd_addr  = i_araddr;
      rd_size  = clip_size(i_arsize);
      rd_burst = i_arburst;
      rd_beat  = '0;
      rd_len   = i_arlen;
      rd_id    = i_arid;
      rd_bad   = (i_arsize > 3'd3) || i_arburst[1];
    end else begin
      rd_addr  = addr_q;
      rd_size  = size_q;
      rd_burst = burst_q;
      rd_beat  = beat_q;
      rd_len   = len_q;
      rd_id    = id_q;
      rd_bad   = err_q;
    end
    rd_oob = rd_addr >= MEM_SIZE;
  end

  assign grant_w = i_awvalid && (!i_arvalid || !last_wr_q);
  assign grant_r = i_arvalid && !grant_w;
  assign wr_oob  = addr_q >= MEM_SIZE;
  assign wr_end  = beat_q[7:0] == len_q;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    o_awready = 1'b0;
    o_arready = 1'b0;
    o_wready  = 1'b0;
    load_rd   = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        o_awready = !rst && grant_w;
        o_arready = !rst && grant_r;
        if (grant_w) begin
          id_d      = i_awid;
          addr_d    = i_awaddr;
          len_d     = i_awlen;
          size_d    = clip_size(i_awsize);
          burst_d   = i_awburst;
          beat_d    = '0;
          err_d     = (i_awsize > 3'd3) || i_awburst[1];
          last_wr_d = 1'b1;
          state_d   = WRITE;
        end else if (grant_r) begin
          id_d      = i_arid;
          len_d     = i_arlen;
          size_d    = clip_size(i_arsize);
          burst_d   = i_arburst;
          err_d     = rd_bad;
          last_wr_d = 1'b0;
          load_rd   = 1'b1;
          state_d   = READ;
        end
      end
      WRITE: begin
        o_wready = 1'b1;
        if (i_wvalid) begin
          mem_we = !wr_oob && !burst_q[1];
          if (wr_oob || (i_wlast != wr_end)) err_d = 1'b1;
          addr_d = step_addr(addr_q, size_q, burst_q);
          beat_d = beat_q + 9'd1;
          if (wr_end) state_d = WRESP;
        end
      end
      WRESP: begin
        if (i_bready) state_d = IDLE;
      end
      READ: begin
        if (rvalid_q && i_rready && rlast_q) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end else if ((!rvalid_q || i_rready) && (beat_q <= {1'b0, len_q})) begin
          load_rd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_rd) begin
      rvalid_d = 1'b1;
      rdata_d  = (rd_oob || rd_burst[1]) ? '0 : mem[rd_addr[AW-1:3]];
      rresp_d  = (rd_oob || rd_bad) ? 2'b10 : 2'b00;
      rlast_d  = rd_beat == {1'b0, rd_len};
      rid_d    = rd_id;
      addr_d   = step_addr(rd_addr, rd_size, rd_burst);
      beat_d   = rd_beat + 9'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (i_wstrb[b]) mem[addr_q[AW-1:3]][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_bvalid = state_q == WRESP;
  assign o_bid    = id_q;
  assign o_bresp  = (state_q == WRESP && err_q) ? 2'b10 : 2'b00;
  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
  assign o_rresp  = rresp_q;
  assign o_rlast  = rlast_q;
  assign o_rid    = rid_q;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Scoreboard bench for axi_ram_responder: a word-array reference model predicts B and R
// responses at issue time; a negedge monitor pops and compares them and checks handshake timing.
module tb_axi_ram_responder;

  localparam int unsigned IDW = 6;
  localparam int unsigned MSZ = 32'h10000;

  logic           clk, rst;
  logic [IDW-1:0] i_awid, i_arid, o_bid, o_rid;
  logic [31:0]    i_awaddr, i_araddr;
  logic [7:0]     i_awlen, i_arlen, i_wstrb;
  logic [2:0]     i_awsize, i_arsize;
  logic [1:0]     i_awburst, i_arburst, o_bresp, o_rresp;
  logic           i_awvalid, o_awready, i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
  logic           i_arvalid, o_arready, o_rlast, o_rvalid, i_rready;
  logic [63:0]    i_wdata, o_rdata;

  axi_ram_responder #(.ID_WIDTH(IDW), .MEM_SIZE(MSZ), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
    .o_wready(o_wready), .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid),
    .i_bready(i_bready), .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arvalid(i_arvalid),
    .o_arready(o_arready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready)
  );

  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [IDW-1:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      exp_b[$];
  r_exp_t      exp_r[$];
  bit          grant_log[$];
  logic [63:0] mref [MSZ/8];
  logic [63:0] wdat [256];
  logic [7:0]  wstb [256];
  int          checks = 0, errors = 0, r_count = 0, rmode = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT, %0d checks %0d errors so far", name, checks, errors);
    $fatal(1);
  endtask

  // Reference model: beat addresses in closed form, memory as a plain word array.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int unsigned i,
                                            input logic [2:0] sz, input logic [1:0] b);
    int unsigned bytes;
    bytes = 1 << ((sz > 3) ? 3 : sz);
    if (b == 2'b00) return a;
    return a + i * bytes;
  endfunction

  task automatic model_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad_last);
    bit          err;
    logic [31:0] a;
    b_exp_t      e;
    err = (size > 3) || (burst >= 2);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, i, size, burst);
      if (a >= MSZ) err = 1;
      else if (burst < 2)
        for (int k = 0; k < 8; k++) if (wstb[i][k]) mref[a >> 3][k*8 +: 8] = wdat[i][k*8 +: 8];
      if (i == bad_last) err = 1;
    end
    e.id = id;
    e.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(e);
  endtask

  task automatic model_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    bit          oob;
    r_exp_t      e;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, i, size, burst);
      oob = a >= MSZ;
      e.id   = id;
      e.data = (oob || burst >= 2) ? 64'h0 : mref[a >> 3];
      e.resp = (oob || burst >= 2 || size > 3) ? 2'b10 : 2'b00;
      e.last = i == int'(len);
      exp_r.push_back(e);
    end
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                          input bit gaps);
    int n;
    model_write(id, addr, len, size, burst, bad_last);
    @(posedge clk); #1;
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
    i_awvalid = 1;
    n = 0;
    @(negedge clk);
    while (!o_awready) begin
      n++;
      if (n > 500) timeout_fail("aw_handshake");
      @(negedge clk);
    end
    @(posedge clk); #1;
    i_awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps) begin
        i_wvalid = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      i_wdata = wdat[b]; i_wstrb = wstb[b];
      i_wlast = (b == int'(len)) ^ (b == bad_last);
      i_wvalid = 1;
      n = 0;
      @(negedge clk);
      while (!o_wready) begin
        n++;
        if (n > 500) timeout_fail("w_handshake");
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    i_wvalid = 0;
    i_wlast = 0;
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    model_read(id, addr, len, size, burst);
    @(posedge clk); #1;
    i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
    i_arvalid = 1;
    n = 0;
    @(negedge clk);
    while (!o_arready) begin
      n++;
      if (n > 500) timeout_fail("ar_handshake");
      @(negedge clk);
    end
    @(posedge clk); #1;
    i_arvalid = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_b.size() != 0 || exp_r.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 4000) timeout_fail("response_drain");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_readies"}, {o_awready, o_arready, o_wready}, 0);
    chk({tag, "_valids"}, {o_bvalid, o_rvalid, o_rlast}, 0);
    chk({tag, "_resp_ids"}, {o_bresp, o_rresp, o_bid, o_rid}, 0);
    chk({tag, "_rdata"}, o_rdata, 0);
  endtask

  task automatic fill_beats(input int n);
    for (int i = 0; i < n; i++) begin
      wdat[i] = {$urandom, $urandom};
      wstb[i] = 8'hFF;
    end
  endtask

  // Response-side driver: 0 = always ready, 1 = random, 2 = left to the stimulus.
  initial begin
    i_rready = 1;
    i_bready = 1;
    forever begin
      @(posedge clk); #1;
      if (rmode == 0) begin i_rready = 1; i_bready = 1; end
      else if (rmode == 1) begin
        i_rready = 1'($urandom_range(0, 1));
        i_bready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor
  bit             p_aw, p_ar, p_more, p_wlast, p_idle, p_hold;
  logic [63:0]    h_data;
  logic [IDW+2:0] h_meta;
  int             wcnt, wlen;

  always @(negedge clk) begin
    if (rst) begin
      p_aw = 0; p_ar = 0; p_more = 0; p_wlast = 0; p_idle = 0; p_hold = 0;
    end else begin
      if (p_aw)    chk("wready_after_aw", o_wready, 1);
      if (p_ar)    chk("rvalid_after_ar", o_rvalid, 1);
      if (p_more)  chk("r_next_beat", o_rvalid, 1);
      if (p_wlast) chk("bvalid_after_wlast", o_bvalid, 1);
      if (p_idle)  chk("idle_after_resp", {o_rvalid, o_bvalid, o_wready}, 0);
      if (p_hold) begin
        chk("r_hold_valid", o_rvalid, 1);
        chk("r_hold_data", o_rdata, h_data);
        chk("r_hold_meta", {o_rresp, o_rlast, o_rid}, h_meta);
      end
      if (i_awvalid && i_arvalid) chk("single_grant", o_awready && o_arready, 0);

      p_aw = i_awvalid && o_awready;
      p_ar = i_arvalid && o_arready;
      if (p_aw) begin grant_log.push_back(1); wcnt = 0; wlen = int'(i_awlen); end
      if (p_ar) grant_log.push_back(0);
      p_wlast = 0;
      if (i_wvalid && o_wready) begin
        p_wlast = wcnt == wlen;
        wcnt++;
      end
      p_idle = 0;
      p_more = 0;
      if (o_bvalid && i_bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          b_exp_t e;
          e = exp_b.pop_front();
          chk("b_id", o_bid, e.id);
          chk("b_resp", o_bresp, e.resp);
        end
        p_idle = 1;
      end
      if (o_rvalid && i_rready) begin
        r_count++;
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          r_exp_t e;
          e = exp_r.pop_front();
          chk("r_data", o_rdata, e.data);
          chk("r_resp_last_id", {o_rresp, o_rlast, o_rid}, {e.resp, e.last, e.id});
          p_idle = e.last;
          p_more = !e.last;
        end
      end
      p_hold = o_rvalid && !i_rready;
      h_data = o_rdata;
      h_meta = {o_rresp, o_rlast, o_rid};
    end
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  ln;
    logic [2:0]  sz;
    logic [1:0]  bu;
    int          sel, bad, rc0;
    for (int i = 0; i < int'(MSZ / 8); i++) mref[i] = '0;
    rst = 1;
    i_awvalid = 0; i_wvalid = 0; i_arvalid = 0; i_wlast = 0;
    i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0;
    i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0;
    i_wdata = '0; i_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;

    // Ties from reset: W,R  W,R  then a lone W, then R must win the next tie.
    grant_log.delete();
    for (int t = 0; t < 3; t++) begin
      if (t == 2) begin
        fill_beats(1);
        do_write(6'd7, 32'h1800, 8'd0, 3'd3, 2'b01, -1, 0);
        wait_drain();
      end
      fill_beats(2);
      fork
        do_write(6'd1 + 6'(t), 32'h1000 + 32'(t) * 32'h40, 8'd1, 3'd3, 2'b01, -1, 0);
        do_read(6'd10 + 6'(t), 32'h1400 + 32'(t) * 32'h40, 8'd1, 3'd3, 2'b01);
      join
      wait_drain();
    end
    chk("grant_log_len", grant_log.size(), 7);
    for (int i = 0; i < 7 && i < grant_log.size(); i++)
      chk("grant_order", grant_log[i], (i % 2 == 0) ? 1 : 0);

    // Single strobed beat then read-back.
    wdat[0] = 64'h1122334455667788; wstb[0] = 8'h0F;
    do_write(6'd5, 32'h100, 8'd0, 3'd3, 2'b01, -1, 0);
    wait_drain();
    do_read(6'd6, 32'h100, 8'd0, 3'd3, 2'b01);
    wait_drain();

    // INCR len 3 with data 1..4
    for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; end
    do_write(6'd2, 32'h200, 8'd3, 3'd3, 2'b01, -1, 0);
    wait_drain();
    do_read(6'd3, 32'h200, 8'd3, 3'd3, 2'b01);
    wait_drain();

    // Back-pressure on R: rready 0,1,0,1
    fill_beats(2);
    do_write(6'd4, 32'h300, 8'd1, 3'd3, 2'b01, -1, 0);
    wait_drain();
    rmode = 2;
    @(posedge clk); #1; i_rready = 0;
    rc0 = r_count;
    do_read(6'd8, 32'h300, 8'd1, 3'd3, 2'b01);
    @(posedge clk); #1; i_rready = 1;
    @(posedge clk); #1; i_rready = 0;
    @(posedge clk); #1; i_rready = 1;
    @(posedge clk); #1; i_rready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rready_toggle_beats", r_count - rc0, 2);
    chk("rready_toggle_drained", exp_r.size(), 0);
    rmode = 0;
    wait_drain();

    // Top-of-memory span, bad bursts, oversize beats, wlast mismatch
    do_read(6'd9, MSZ - 8, 8'd1, 3'd3, 2'b01);
    wait_drain();
    fill_beats(2);
    do_write(6'd11, MSZ - 8, 8'd1, 3'd3, 2'b01, -1, 0);
    wait_drain();
    do_read(6'd12, MSZ - 8, 8'd1, 3'd3, 2'b01);
    fill_beats(2);
    wait_drain();
    do_write(6'd13, 32'h400, 8'd1, 3'd3, 2'b10, -1, 0);
    wait_drain();
    do_read(6'd14, 32'h400, 8'd1, 3'd3, 2'b01);
    wait_drain();
    do_read(6'd15, 32'h200, 8'd1, 3'd3, 2'b11);
    wait_drain();
    do_read(6'd16, 32'h200, 8'd1, 3'd5, 2'b01);
    wait_drain();
    fill_beats(3);
    do_write(6'd17, 32'h500, 8'd2, 3'd3, 2'b01, 0, 0);
    wait_drain();

    // Randomised traffic
    rmode = 1;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      ln = 8'($urandom_range(0, 7));
      sz = 3'd3;
      if (sel < 7) a = 32'($urandom_range(0, 'h3FF)) << 3;
      else if (sel < 9) a = MSZ - 8 * $urandom_range(1, 4);
      else begin a = 32'($urandom_range(0, 'h1FFF)); sz = 3'($urandom_range(0, 2)); end
      if ($urandom_range(0, 11) == 0) sz = 3'($urandom_range(4, 7));
      sel = $urandom_range(0, 9);
      bu = (sel == 0) ? 2'($urandom_range(2, 3)) : (sel < 3) ? 2'b00 : 2'b01;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(ln); i++) begin
          wdat[i] = {$urandom, $urandom};
          wstb[i] = 8'($urandom);
        end
        bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, int'(ln)) : -1;
        do_write(6'($urandom), a, ln, sz, bu, bad, 1);
      end else begin
        do_read(6'($urandom), a, ln, sz, bu);
      end
      wait_drain();
    end
    rmode = 0;

    // Reset while beat 1 of a len-3 read is on the bus
    do_read(6'd20, 32'h200, 8'd3, 3'd3, 2'b01);
    @(posedge clk); #1;
    rst = 1;
    exp_r.delete();
    #1;
    check_reset_outputs("midread_reset");
    @(negedge clk);
    check_reset_outputs("midread_reset_next");
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    do_read(6'd21, 32'h200, 8'd3, 3'd3, 2'b01);
    wait_drain();
    do_read(6'd22, 32'h100, 8'd0, 3'd3, 2'b01);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
